// File: rtl/lcd_pkg.sv
// Shared constants and state types for the character LCD controller.
// Build option: LCD_DIRTY_REFRESH_EN enables the idle-until-dirty refresh mode.
package lcd_pkg;

  localparam logic [7:0] FUNC_2L   = 8'h38;
  localparam logic [7:0] FUNC_1L   = 8'h30;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] ENTRY_INC = 8'h06;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] LINE0     = 8'h80;
  localparam logic [7:0] LINE1     = 8'hC0;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    ADDR,
    CHAR,
    IDLE
  } main_st_e;

  typedef enum logic [2:0] {
    T_IDLE,
    T_SETUP,
    T_EHI,
    T_HOLD,
    T_WAIT
  } xfer_st_e;

  function automatic logic [7:0] init_cmd(
    input logic [1:0] step,
    input logic       two_line
  );
    logic [7:0] c;
    case (step)
      2'd0:    c = two_line ? FUNC_2L : FUNC_1L;
      2'd1:    c = DISP_ON;
      2'd2:    c = ENTRY_INC;
      default: c = CLEAR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_xfer.sv
// One-byte LCD write engine: setup, E pulse, hold, then execution wait.
// Build option: none (LCD_DIRTY_REFRESH_EN only affects the top).
module lcd_xfer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC   = 4,
  parameter int E_PULSE_CYC = 25,
  parameter int HOLD_CYC    = 4,
  parameter int EXEC_CYC    = 2500,
  parameter int CLEAR_CYC   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] byte_i,
  input  logic       long_i,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [7:0] data_o,
  output logic       done_o
);

  xfer_st_e    st_q, st_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  dat_q, dat_d;
  logic        rs_q, rs_d;
  logic        long_q, long_d;
  logic        e_q, e_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= T_IDLE;
      cnt_q  <= '0;
      dat_q  <= '0;
      rs_q   <= 1'b0;
      long_q <= 1'b0;
      e_q    <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      dat_q  <= dat_d;
      rs_q   <= rs_d;
      long_q <= long_d;
      e_q    <= e_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    dat_d  = dat_q;
    rs_d   = rs_q;
    long_d = long_q;
    done_o = 1'b0;
    unique case (st_q)
      T_IDLE: begin
        if (start_i) begin
          st_d   = T_SETUP;
          cnt_d  = 32'(SETUP_CYC - 1);
          dat_d  = byte_i;
          rs_d   = rs_i;
          long_d = long_i;
        end
      end
      T_SETUP: begin
        if (cnt_q == 32'd0) begin
          st_d  = T_EHI;
          cnt_d = 32'(E_PULSE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      T_EHI: begin
        if (cnt_q == 32'd0) begin
          st_d  = T_HOLD;
          cnt_d = 32'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      T_HOLD: begin
        if (cnt_q == 32'd0) begin
          st_d  = T_WAIT;
          cnt_d = long_q ? 32'(CLEAR_CYC - 1)
                         : 32'(EXEC_CYC - 1);
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      T_WAIT: begin
        if (cnt_q == 32'd0) begin
          st_d   = T_IDLE;
          done_o = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: st_d = T_IDLE;
    endcase
  end

  // E comes straight from a flop so the strobe is glitch-free.
  assign e_d      = (st_d == T_EHI);
  assign lcd_e_o  = e_q;
  assign lcd_rs_o = rs_q;
  assign data_o   = dat_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780 text controller: power-up, init, then buffer refresh to the panel.
// Build option: LCD_DIRTY_REFRESH_EN idles after a frame until a write lands.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int COLS        = 16,
  parameter int LINES       = 2,
  parameter int POWERUP_CYC = 750000,
  parameter int SETUP_CYC   = 4,
  parameter int E_PULSE_CYC = 25,
  parameter int HOLD_CYC    = 4,
  parameter int EXEC_CYC    = 2500,
  parameter int CLEAR_CYC   = 100000,
  localparam int CW = $clog2(COLS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic          wr_line,
  input  logic [CW-1:0] wr_col,
  input  logic [7:0]    wr_char,
  output logic          wr_err,
  output logic          init_done,
  output logic          frame_done,
  output logic          lcd_e,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_on,
  output logic          lcd_blon,
  output logic [7:0]    data_lcd
);

  localparam int NCELL = LINES * COLS;
  localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam logic [CW-1:0] COLS_C    = CW'(COLS);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic          LAST_LINE = (LINES > 1);
  localparam logic          TWO_LINE  = (LINES > 1);

  main_st_e    st_q, st_d;
  logic [31:0] pw_q, pw_d;
  logic [1:0]  step_q, step_d;
  logic        line_q, line_d;
  logic [CW-1:0] col_q, col_d;
  logic        busy_q, busy_d;
  logic        init_q, init_d;
  logic        frame_q, frame_d;
  logic        err_q;
  logic [7:0]  buf_q [NCELL];

  logic          x_start, x_rs, x_long, x_done;
  logic [7:0]    x_byte;
  logic [7:0]    rd_char;
  logic [IW-1:0] rd_idx, wr_idx;
  logic          wr_acc, wr_inr, wr_line_eff;

  assign wr_line_eff = TWO_LINE ? wr_line : 1'b0;
  assign wr_acc = wr_valid && init_q;
  assign wr_inr = (wr_col < COLS_C) &&
                  (TWO_LINE || !wr_line);
  assign wr_idx = IW'(32'(wr_line_eff) * COLS +
                      32'(wr_col));
  assign rd_idx = IW'(32'(line_q) * COLS +
                      32'(col_q));
  assign rd_char = buf_q[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCELL; i++) begin
        buf_q[i] <= 8'h20;
      end
    end else if (wr_acc && wr_inr) begin
      buf_q[wr_idx] <= wr_char;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (wr_acc && !wr_inr) begin
      err_q <= 1'b1;
    end
  end

`ifdef LCD_DIRTY_REFRESH_EN
  logic dirty_q, dirty_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dirty_q <= 1'b0;
    end else begin
      dirty_q <= dirty_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= PWRUP;
      pw_q    <= '0;
      step_q  <= '0;
      line_q  <= 1'b0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      init_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      pw_q    <= pw_d;
      step_q  <= step_d;
      line_q  <= line_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      init_q  <= init_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    pw_d    = pw_q;
    step_d  = step_q;
    line_d  = line_q;
    col_d   = col_q;
    init_d  = init_q;
    frame_d = 1'b0;
    x_rs    = 1'b0;
    x_byte  = 8'h00;
    x_long  = 1'b0;
    unique case (st_q)
      PWRUP: begin
        if (pw_q == 32'(POWERUP_CYC - 1)) begin
          st_d = INIT;
          pw_d = '0;
        end else begin
          pw_d = pw_q + 32'd1;
        end
      end
      INIT: begin
        x_byte = init_cmd(step_q, TWO_LINE);
        x_long = (step_q == 2'd3);
        if (x_done) begin
          if (step_q == 2'd3) begin
            st_d   = ADDR;
            init_d = 1'b1;
            line_d = 1'b0;
            col_d  = '0;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      ADDR: begin
        x_byte = line_q ? LINE1 : LINE0;
        if (x_done) begin
          st_d  = CHAR;
          col_d = '0;
        end
      end
      CHAR: begin
        x_rs   = 1'b1;
        x_byte = rd_char;
        if (x_done) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (line_q == LAST_LINE) begin
              frame_d = 1'b1;
              line_d  = 1'b0;
`ifdef LCD_DIRTY_REFRESH_EN
              st_d    = IDLE;
`else
              st_d    = ADDR;
`endif
            end else begin
              line_d = 1'b1;
              st_d   = ADDR;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
`ifdef LCD_DIRTY_REFRESH_EN
      IDLE: begin
        if (dirty_q) begin
          st_d = ADDR;
        end
      end
`endif
      default: st_d = PWRUP;
    endcase
  end

  // A byte is launched whenever the engine is free in a sending state.
  always_comb begin
    x_start = ((st_q == INIT) || (st_q == ADDR) ||
               (st_q == CHAR)) && !busy_q;
    busy_d = busy_q;
    if (x_start) begin
      busy_d = 1'b1;
    end else if (x_done) begin
      busy_d = 1'b0;
    end
  end

`ifdef LCD_DIRTY_REFRESH_EN
  // A write on the same clock as the clear wins, forcing another frame.
  always_comb begin
    dirty_d = dirty_q;
    if (wr_acc && wr_inr) begin
      dirty_d = 1'b1;
    end else if ((st_d == ADDR) && (st_q != ADDR) &&
                 !line_d) begin
      dirty_d = 1'b0;
    end
  end
`endif

  lcd_xfer #(
    .SETUP_CYC  (SETUP_CYC),
    .E_PULSE_CYC(E_PULSE_CYC),
    .HOLD_CYC   (HOLD_CYC),
    .EXEC_CYC   (EXEC_CYC),
    .CLEAR_CYC  (CLEAR_CYC)
  ) u_xfer (
    .clk     (clk),
    .rst     (rst),
    .start_i (x_start),
    .rs_i    (x_rs),
    .byte_i  (x_byte),
    .long_i  (x_long),
    .lcd_e_o (lcd_e),
    .lcd_rs_o(lcd_rs),
    .data_o  (data_lcd),
    .done_o  (x_done)
  );

  assign wr_ready   = init_q;
  assign init_done  = init_q;
  assign frame_done = frame_q;
  assign wr_err     = err_q;
  assign lcd_rw     = 1'b0;
  assign lcd_on     = 1'b1;
  assign lcd_blon   = 1'b1;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Randomised bench for lcd_text_ctrl against a transfer-level panel model.
// Build option: LCD_DIRTY_REFRESH_EN selects the idle-refresh scenario.
module tb_lcd_text_ctrl;

  localparam int COLS = 4;
  localparam int LINES = 2;
  localparam int PWR = 20;
  localparam int SU = 2;
  localparam int EP = 4;
  localparam int HD = 2;
  localparam int EX = 8;
  localparam int CL = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_line = 1'b0;
  logic [2:0] wr_col = '0;
  logic [7:0] wr_char = '0;
  logic       wr_ready, wr_err, init_done, frame_done;
  logic       lcd_e, lcd_rs, lcd_rw, lcd_on, lcd_blon;
  logic [7:0] data_lcd;

  lcd_text_ctrl #(
    .COLS(COLS), .LINES(LINES), .POWERUP_CYC(PWR),
    .SETUP_CYC(SU), .E_PULSE_CYC(EP), .HOLD_CYC(HD),
    .EXEC_CYC(EX), .CLEAR_CYC(CL)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_line(wr_line), .wr_col(wr_col),
    .wr_char(wr_char), .wr_err(wr_err),
    .init_done(init_done), .frame_done(frame_done),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_on(lcd_on), .lcd_blon(lcd_blon),
    .data_lcd(data_lcd)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model state: panel buffer plus per-edge snapshots for sampling.
  int         cyc = 0;
  int         rel = 0;
  logic [7:0] mbuf [8];
  logic [7:0] hist [8][8];
  logic       mwerr = 1'b0;
  logic       mdirty = 1'b0;
  logic       minit = 1'b0;

  int         nrise = 0;
  int         nframe = 0;
  int         nfstart = 0;
  int         rlast = 0;
  int         flast = -1;
  int         f4 = -1;
  int         fexp = -1;
  int         hold_left = 0;
  logic       prev_e = 1'b0;
  logic       prev_clear = 1'b0;
  logic       prev_fend = 1'b0;
  logic [8:0] cur = '0;
  logic [8:0] busr [8];
  logic [8:0] cap [64];

  always @(posedge clk) begin : model_wr
    cyc++;
    for (int i = 0; i < 8; i++) hist[cyc % 8][i] = mbuf[i];
    if (rst) begin
      for (int i = 0; i < 8; i++) mbuf[i] = 8'h20;
      mwerr = 1'b0;
      mdirty = 1'b0;
    end else if (wr_valid && minit) begin
      if (wr_col < 3'd4) begin
        mbuf[int'(wr_line) * COLS + int'(wr_col)] = wr_char;
        mdirty = 1'b1;
      end else begin
        mwerr = 1'b1;
      end
    end
  end

  function automatic logic [8:0] exp_xfer(input int k, input int r);
    int j, ln, cl;
    logic [8:0] e;
    if (k == 0) e = 9'h038;
    else if (k == 1) e = 9'h00C;
    else if (k == 2) e = 9'h006;
    else if (k == 3) e = 9'h001;
    else begin
      j = (k - 4) % 10;
      if (j == 0) e = 9'h080;
      else if (j == 5) e = 9'h0C0;
      else begin
        ln = (j > 5) ? 1 : 0;
        cl = (j > 5) ? j - 6 : j - 1;
        e = {1'b1, hist[(r - SU) % 8][ln * COLS + cl]};
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin : cmp
    logic [8:0] bus;
    int r, f, k, lo;
    bus = {lcd_rs, data_lcd};
    busr[cyc % 8] = bus;
    chk("lcd_rw", lcd_rw, 0);
    chk("lcd_on", lcd_on, 1);
    chk("lcd_blon", lcd_blon, 1);
    if (rst) begin
      chk("rst_e", lcd_e, 0);
      chk("rst_bus", bus, 0);
      chk("rst_init", init_done, 0);
      chk("rst_ready", wr_ready, 0);
      chk("rst_frame", frame_done, 0);
      chk("rst_err", wr_err, 0);
      minit = 1'b0; nrise = 0; nframe = 0; nfstart = 0;
      flast = -1; f4 = -1; fexp = -1; hold_left = 0;
      prev_e = 1'b0;
    end else begin
      minit = (f4 >= 0) && (cyc >= f4 + HD + CL);
      chk("init_done", init_done, minit);
      chk("wr_ready", wr_ready, minit);
      chk("frame_done", frame_done, cyc == fexp);
      chk("wr_err", wr_err, mwerr);
      if (frame_done) nframe++;
      if (lcd_e && !prev_e) begin
        r = cyc;
        k = nrise;
        nrise++;
        if (k == 0) chk("pwrup_gap", (r - rel) >= PWR + SU, 1);
        else if (flast >= 0) begin
          lo = HD + (prev_clear ? CL : EX) + SU;
          chk("gap_min", (r - flast) >= lo, 1);
`ifdef LCD_DIRTY_REFRESH_EN
          if (!prev_fend) chk("gap_max", (r - flast) <= lo + 2, 1);
`else
          chk("gap_max", (r - flast) <= lo + 2, 1);
`endif
        end
        for (int i = 1; i <= SU; i++)
          chk("setup_bus", busr[(r - i) % 8], bus);
        chk("xfer_byte", bus, exp_xfer(k, r));
        if (k < 64) cap[k] = bus;
        if (k >= 4 && (k - 4) % 10 == 0) begin
`ifdef LCD_DIRTY_REFRESH_EN
          if (nfstart > 0) chk("dirty_gate", mdirty, 1);
`endif
          mdirty = 1'b0;
          nfstart++;
        end
        cur = bus;
        rlast = r;
      end
      if (!lcd_e && prev_e) begin
        f = cyc;
        k = nrise - 1;
        chk("e_width", f - rlast, EP);
        hold_left = HD;
        flast = f;
        prev_clear = (cur == 9'h001);
        prev_fend = (k >= 4) && ((k - 4) % 10 == 9);
        if (k == 3) f4 = f;
        if (prev_fend) fexp = f + HD + EX;
      end
      if (hold_left > 0) begin
        chk("hold_bus", bus, cur);
        hold_left--;
      end
      prev_e = lcd_e;
    end
  end

  localparam logic [8:0] F1 [14] = '{
    9'h038, 9'h00C, 9'h006, 9'h001,
    9'h080, 9'h120, 9'h120, 9'h120, 9'h120,
    9'h0C0, 9'h120, 9'h120, 9'h120, 9'h120};
  localparam logic [8:0] F2 [10] = '{
    9'h080, 9'h120, 9'h120, 9'h120, 9'h120,
    9'h0C0, 9'h120, 9'h120, 9'h141, 9'h120};
  localparam logic [8:0] F3 [10] = '{
    9'h080, 9'h120, 9'h120, 9'h120, 9'h142,
    9'h0C0, 9'h120, 9'h120, 9'h141, 9'h120};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic l, input logic [2:0] c,
                    input logic [7:0] ch);
    wr_valid = 1'b1; wr_line = l; wr_col = c; wr_char = ch;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (nframe < n && t < budget) begin tick(); t++; end
    chk("frame_timeout", nframe >= n, 1);
  endtask

  task automatic wait_rises(input int n, input int budget);
    int t = 0;
    while (nrise < n && t < budget) begin tick(); t++; end
    chk("rise_timeout", nrise >= n, 1);
  endtask

  task automatic chk_init_frame();
    for (int i = 0; i < 14; i++) chk("lit_f1", cap[i], F1[i]);
  endtask

  initial begin : stim
    int t;
    repeat (3) tick();
    rst = 1'b0;
    rel = cyc;
    wait_frames(1, 2000);
    chk_init_frame();
`ifdef LCD_DIRTY_REFRESH_EN
    repeat (500) tick();
    chk("idle_quiet1", nrise, 14);
    wr(1'b1, 3'd2, 8'h41);
`else
    wait_rises(15, 400);
    wr(1'b1, 3'd2, 8'h41);
`endif
    wait_frames(2, 1000);
    wr(1'b0, 3'd5, 8'h5A);
    wr(1'b0, 3'd3, 8'h42);
    wait_frames(3, 1000);
    for (int i = 0; i < 10; i++) chk("lit_f2", cap[14 + i], F2[i]);
    for (int i = 0; i < 10; i++) chk("lit_f3", cap[24 + i], F3[i]);
    chk("lit_err", wr_err, 1);
`ifdef LCD_DIRTY_REFRESH_EN
    repeat (500) tick();
    chk("idle_quiet2", nrise, 34);
`else
    repeat (800) begin
      wr_valid = ($urandom % 3) == 0;
      wr_line = 1'($urandom % 2);
      wr_col = 3'($urandom % 8);
      wr_char = 8'($urandom_range(32, 126));
      tick();
    end
    wr_valid = 1'b0;
`endif
    wr(1'b1, 3'd0, 8'h55);
    t = 0;
    while (t < 300) begin
      @(negedge clk);
      #1;
      if (lcd_e) break;
      t++;
    end
    chk("find_ehi", lcd_e, 1);
    rst = 1'b1;
    #1;
    chk("async_e", lcd_e, 0);
    chk("async_init", init_done, 0);
    tick();
    tick();
    rst = 1'b0;
    rel = cyc;
    wait_frames(1, 2000);
    chk_init_frame();
    chk("lit_err_clr", wr_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
